// File: rtl/uart_rx_monitor.sv
// uart_rx_monitor: samples a UART line, decodes 8N1 frames and queues bytes on a valid/ready FIFO.
// Build option: define UART_MON_PARITY_EN for 8E1 framing with even-parity checking.
module uart_rx_monitor #(
   parameter int unsigned ClkFreq   = 50_000_000,
   parameter int unsigned BaudRate  = 921_600,
   parameter int unsigned FifoDepth = 4
) (
   input  logic       clk_i,
   input  logic       rst_i,
   input  logic       rx_i,
   output logic [7:0] byte_o,
   output logic       byte_valid_o,
   input  logic       byte_ready_i,
   output logic       frame_err_o,
   output logic       parity_err_o,
   output logic       overflow_o,
   output logic       busy_o
);

   localparam int unsigned ClksPerBit = ClkFreq / BaudRate;
   localparam int unsigned CntW       = $clog2(ClksPerBit);
   localparam int unsigned AddrW      = $clog2(FifoDepth);
   localparam logic [CntW-1:0] HalfBit = CntW'(ClksPerBit / 2 - 1);
   localparam logic [CntW-1:0] FullBit = CntW'(ClksPerBit - 1);

   if (ClksPerBit < 4) begin : g_bad_clks_per_bit
      $error("uart_rx_monitor: ClksPerBit must be >= 4");
   end
   if ((FifoDepth < 2) || ((FifoDepth & (FifoDepth - 1)) != 0)) begin : g_bad_fifo_depth
      $error("uart_rx_monitor: FifoDepth must be a power of two >= 2");
   end

   typedef enum logic [2:0] {
      S_IDLE,
      S_START,
      S_DATA,
      S_PARITY,
      S_STOP,
      S_BREAK
   } state_t;

   logic            r_sync1;
   logic            r_rx_s;
   logic            r_rx_prev;
   logic            w_fall;
   state_t          r_state;
   state_t          w_state_next;
   logic [CntW-1:0] r_cnt;
   logic [2:0]      r_bit_idx;
   logic [7:0]      r_shift;
   logic            w_tick;
   logic            w_load_half;
   logic            w_load_full;
   logic            w_clr_idx;
   logic            w_shift;
   logic            w_stop_eval;
   logic            w_par_bad;
   logic            w_push_req;
   logic            w_frame_req;
   logic            r_push;
   logic [7:0]      r_push_data;
   logic            r_frame_err;
`ifdef UART_MON_PARITY_EN
   logic            w_par_sample;
   logic            r_par_bit;
   logic            r_parity_err;
`endif

   logic [7:0]      r_mem [FifoDepth];
   logic [AddrW:0]  r_wr_ptr;
   logic [AddrW:0]  r_rd_ptr;
   logic            r_overflow;
   logic            w_empty;
   logic            w_full;
   logic            w_pop;
   logic            w_wr_en;

   // Synchroniser resets to idle-high so reset release never looks like a start bit.
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_sync1   <= 1'b1;
         r_rx_s    <= 1'b1;
         r_rx_prev <= 1'b1;
      end else begin
         r_sync1   <= rx_i;
         r_rx_s    <= r_sync1;
         r_rx_prev <= r_rx_s;
      end
   end

   assign w_fall = r_rx_prev & ~r_rx_s;
   assign w_tick = (r_cnt == '0);

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_state <= S_IDLE;
      end else begin
         r_state <= w_state_next;
      end
   end

   always_comb begin
      w_state_next = r_state;
      case (r_state)
         S_IDLE:   if (w_fall) w_state_next = S_START;
         S_START:  if (w_tick) w_state_next = r_rx_s ? S_IDLE : S_DATA;
`ifdef UART_MON_PARITY_EN
         S_DATA:   if (w_tick && (r_bit_idx == 3'd7)) w_state_next = S_PARITY;
         S_PARITY: if (w_tick) w_state_next = S_STOP;
`else
         S_DATA:   if (w_tick && (r_bit_idx == 3'd7)) w_state_next = S_STOP;
`endif
         S_STOP:   if (w_tick) w_state_next = r_rx_s ? S_IDLE : S_BREAK;
         S_BREAK:  if (r_rx_s) w_state_next = S_IDLE;
         default:  w_state_next = S_IDLE;
      endcase
   end

   always_comb begin
      w_load_half  = 1'b0;
      w_load_full  = 1'b0;
      w_clr_idx    = 1'b0;
      w_shift      = 1'b0;
      w_stop_eval  = 1'b0;
`ifdef UART_MON_PARITY_EN
      w_par_sample = 1'b0;
`endif
      case (r_state)
         S_IDLE:   w_load_half = w_fall;
         S_START: begin
            if (w_tick && !r_rx_s) begin
               w_load_full = 1'b1;
               w_clr_idx   = 1'b1;
            end
         end
         S_DATA: begin
            if (w_tick) begin
               w_load_full = 1'b1;
               w_shift     = 1'b1;
            end
         end
`ifdef UART_MON_PARITY_EN
         S_PARITY: begin
            if (w_tick) begin
               w_load_full  = 1'b1;
               w_par_sample = 1'b1;
            end
         end
`endif
         S_STOP:   w_stop_eval = w_tick;
         default:  ;
      endcase
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_cnt     <= '0;
         r_bit_idx <= '0;
         r_shift   <= '0;
      end else begin
         if (w_load_half) begin
            r_cnt <= HalfBit;
         end else if (w_load_full) begin
            r_cnt <= FullBit;
         end else if (!w_tick) begin
            r_cnt <= r_cnt - CntW'(1);
         end
         if (w_clr_idx) begin
            r_bit_idx <= '0;
         end else if (w_shift) begin
            r_bit_idx <= r_bit_idx + 3'd1;
         end
         if (w_shift) begin
            r_shift <= {r_rx_s, r_shift[7:1]};
         end
      end
   end

`ifdef UART_MON_PARITY_EN
   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_par_bit    <= 1'b0;
         r_parity_err <= 1'b0;
      end else begin
         if (w_par_sample) r_par_bit <= r_rx_s;
         r_parity_err <= w_stop_eval & w_par_bad;
      end
   end

   assign w_par_bad    = (^r_shift) ^ r_par_bit;
   assign parity_err_o = r_parity_err;
`else
   assign w_par_bad    = 1'b0;
   assign parity_err_o = 1'b0;
`endif

   assign w_push_req  = w_stop_eval & r_rx_s & ~w_par_bad;
   assign w_frame_req = w_stop_eval & ~r_rx_s;

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_push      <= 1'b0;
         r_push_data <= '0;
         r_frame_err <= 1'b0;
      end else begin
         r_push      <= w_push_req;
         r_frame_err <= w_frame_req;
         if (w_push_req) r_push_data <= r_shift;
      end
   end

   // Pointers carry one extra wrap bit: equal means empty, MSB-only difference means full.
   assign w_empty = (r_wr_ptr == r_rd_ptr);
   assign w_full  = (r_wr_ptr[AddrW] != r_rd_ptr[AddrW]) &&
                    (r_wr_ptr[AddrW-1:0] == r_rd_ptr[AddrW-1:0]);
   assign w_pop   = ~w_empty & byte_ready_i;
   assign w_wr_en = r_push & (~w_full | w_pop);

   always_ff @(posedge clk_i) begin
      if (w_wr_en) r_mem[r_wr_ptr[AddrW-1:0]] <= r_push_data;
   end

   always_ff @(posedge clk_i or posedge rst_i) begin
      if (rst_i) begin
         r_wr_ptr   <= '0;
         r_rd_ptr   <= '0;
         r_overflow <= 1'b0;
      end else begin
         if (w_wr_en) r_wr_ptr <= r_wr_ptr + (AddrW + 1)'(1);
         if (w_pop)   r_rd_ptr <= r_rd_ptr + (AddrW + 1)'(1);
         if (r_push && w_full && !w_pop) r_overflow <= 1'b1;
      end
   end

   assign byte_o       = w_empty ? '0 : r_mem[r_rd_ptr[AddrW-1:0]];
   assign byte_valid_o = ~w_empty;
   assign frame_err_o  = r_frame_err;
   assign overflow_o   = r_overflow;
   assign busy_o       = (r_state != S_IDLE);

endmodule

// File: tb/tb_uart_rx_monitor.sv
// Scoreboard bench for uart_rx_monitor at 16 clocks per bit; covers parity when UART_MON_PARITY_EN is defined.
module tb_uart_rx_monitor;

   localparam int CPB = 16;
`ifdef UART_MON_PARITY_EN
   localparam int FRAME_BITS = 11;
`else
   localparam int FRAME_BITS = 10;
`endif
   localparam int FRAME_CYC = FRAME_BITS * CPB;
   localparam int VALID_LAT = 3 + 8 + (FRAME_BITS - 1) * CPB + 1;

   logic       clk_i = 1'b0;
   logic       rst_i;
   logic       rx_i;
   logic       byte_ready_i;
   logic [7:0] byte_o;
   logic       byte_valid_o;
   logic       frame_err_o;
   logic       parity_err_o;
   logic       overflow_o;
   logic       busy_o;

   int         checks   = 0;
   int         failures = 0;
   logic [7:0] exp_q [$];
`ifdef UART_MON_PARITY_EN
   logic       bad_par = 1'b0;
`endif

   uart_rx_monitor #(
      .ClkFreq   (160),
      .BaudRate  (10),
      .FifoDepth (4)
   ) dut (
      .clk_i        (clk_i),
      .rst_i        (rst_i),
      .rx_i         (rx_i),
      .byte_o       (byte_o),
      .byte_valid_o (byte_valid_o),
      .byte_ready_i (byte_ready_i),
      .frame_err_o  (frame_err_o),
      .parity_err_o (parity_err_o),
      .overflow_o   (overflow_o),
      .busy_o       (busy_o)
   );

   always #5 clk_i = ~clk_i;

   // Called 1ns after a rising edge; returns 1ns after the edge ending the stop bit.
   task automatic send_frame(input logic [7:0] b, input logic stop_bit);
      rx_i = 1'b0;
      repeat (CPB) @(posedge clk_i);
      #1;
      for (int i = 0; i < 8; i++) begin
         rx_i = b[i];
         repeat (CPB) @(posedge clk_i);
         #1;
      end
`ifdef UART_MON_PARITY_EN
      rx_i = (^b) ^ bad_par;
      repeat (CPB) @(posedge clk_i);
      #1;
`endif
      rx_i = stop_bit;
      repeat (CPB) @(posedge clk_i);
      #1;
   endtask

   task automatic test_reset();
      rst_i = 1'b1;
      rx_i = 1'b1;
      byte_ready_i = 1'b1;
      repeat (3) @(posedge clk_i);
      #2;
      checks++;
      if (byte_o !== 8'h00) begin
         failures++;
         $display("FAIL reset_byte: byte_o=0x%02h expected 0x00", byte_o);
      end
      checks++;
      if ({byte_valid_o, frame_err_o, parity_err_o, overflow_o, busy_o} !== 5'b0) begin
         failures++;
         $display("FAIL reset_flags: valid/ferr/perr/ovf/busy=%b expected 00000",
                  {byte_valid_o, frame_err_o, parity_err_o, overflow_o, busy_o});
      end
      @(posedge clk_i);
      #1 rst_i = 1'b0;
      repeat (5) @(posedge clk_i);
      #2;
      checks++;
      if (busy_o !== 1'b0) begin
         failures++;
         $display("FAIL idle_after_reset: busy_o=%b expected 0", busy_o);
      end
   endtask

   task automatic test_single_byte();
      int first, vcnt, ferr, perr;
      logic [7:0] exp;
      first = 0; vcnt = 0; ferr = 0; perr = 0;
      @(posedge clk_i);
      #1;
      exp_q.push_back(8'h55);
      fork
         send_frame(8'h55, 1'b1);
         begin
            for (int c = 1; c <= FRAME_CYC + 8; c++) begin
               @(posedge clk_i);
               #2;
               if (byte_valid_o) begin
                  vcnt++;
                  if (first == 0) first = c;
               end
               if (byte_valid_o && byte_ready_i) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++;
                     $display("FAIL sb_unexpected: byte_o=0x%02h, no byte expected", byte_o);
                  end else begin
                     exp = exp_q.pop_front();
                     if (byte_o !== exp) begin
                        failures++;
                        $display("FAIL sb_byte: byte_o=0x%02h expected 0x%02h", byte_o, exp);
                     end
                  end
               end
               if (frame_err_o) ferr++;
               if (parity_err_o) perr++;
            end
         end
      join
      checks++;
      if (first != VALID_LAT) begin
         failures++;
         $display("FAIL valid_latency: valid rose at cycle %0d expected %0d", first, VALID_LAT);
      end
      checks++;
      if (vcnt != 1) begin
         failures++;
         $display("FAIL valid_width: valid high %0d cycles expected 1", vcnt);
      end
      checks++;
      if (ferr != 0 || perr != 0) begin
         failures++;
         $display("FAIL clean_frame_errs: frame_err=%0d parity_err=%0d expected 0/0", ferr, perr);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL single_missing: %0d bytes not received expected 0", exp_q.size());
      end
   endtask

   task automatic test_glitch();
      int busy_seen, last_busy, vcnt, ferr;
      busy_seen = 0; last_busy = 0; vcnt = 0; ferr = 0;
      @(posedge clk_i);
      #1;
      rx_i = 1'b0;
      fork
         begin
            repeat (4) @(posedge clk_i);
            #1 rx_i = 1'b1;
         end
         begin
            for (int c = 1; c <= 24; c++) begin
               @(posedge clk_i);
               #2;
               if (busy_o) begin
                  busy_seen = 1;
                  last_busy = c;
               end
               if (byte_valid_o) vcnt++;
               if (frame_err_o) ferr++;
            end
         end
      join
      checks++;
      if (busy_seen != 1) begin
         failures++;
         $display("FAIL glitch_busy: busy seen=%0d expected 1", busy_seen);
      end
      checks++;
      if (last_busy > 12) begin
         failures++;
         $display("FAIL glitch_idle: last busy cycle %0d expected <= 12", last_busy);
      end
      checks++;
      if (vcnt != 0 || ferr != 0) begin
         failures++;
         $display("FAIL glitch_output: valid=%0d frame_err=%0d expected 0/0", vcnt, ferr);
      end
   endtask

   task automatic test_frame_error();
      int ferr;
      logic [7:0] exp;
      ferr = 0;
      @(posedge clk_i);
      #1;
      exp_q.push_back(8'h3C);
      fork
         begin
            send_frame(8'hA5, 1'b0);
            repeat (48) @(posedge clk_i);
            #1 rx_i = 1'b1;
            repeat (20) @(posedge clk_i);
            #1;
            send_frame(8'h3C, 1'b1);
         end
         begin
            for (int c = 1; c <= 2 * FRAME_CYC + 48 + 20 + 10; c++) begin
               @(posedge clk_i);
               #2;
               if (frame_err_o) ferr++;
               if (byte_valid_o && byte_ready_i) begin
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++;
                     $display("FAIL sb_unexpected: byte_o=0x%02h, no byte expected", byte_o);
                  end else begin
                     exp = exp_q.pop_front();
                     if (byte_o !== exp) begin
                        failures++;
                        $display("FAIL sb_byte: byte_o=0x%02h expected 0x%02h", byte_o, exp);
                     end
                  end
               end
            end
         end
      join
      checks++;
      if (ferr != 1) begin
         failures++;
         $display("FAIL frame_err_pulse: %0d cycles high expected 1", ferr);
      end
      checks++;
      if (exp_q.size() != 0) begin
         failures++;
         $display("FAIL after_break_missing: %0d bytes not received expected 0", exp_q.size());
      end
   endtask

   task automatic test_back_to_back();
      int pops, last_pop;
      logic [7:0] exp;
      pops = 0; last_pop = -1;
      byte_ready_i = 1'b0;
      @(posedge clk_i);
      #1;
      for (int k = 1; k <= 5; k++) begin
         if (k <= 4) exp_q.push_back(8'(k));
         send_frame(8'(k), 1'b1);
         checks++;
         if ({byte_valid_o, byte_o} !== {1'b1, 8'h01}) begin
            failures++;
            $display("FAIL hold_head frame %0d: valid=%b byte_o=0x%02h expected 1/0x01",
                     k, byte_valid_o, byte_o);
         end
         checks++;
         if (overflow_o !== (k == 5)) begin
            failures++;
            $display("FAIL overflow frame %0d: overflow_o=%b expected %b", k, overflow_o, (k == 5));
         end
      end
      byte_ready_i = 1'b1;
      #1;
      for (int c = 0; c < 8; c++) begin
         if (byte_valid_o && byte_ready_i) begin
            pops++;
            last_pop = c;
            checks++;
            if (exp_q.size() == 0) begin
               failures++;
               $display("FAIL sb_unexpected: byte_o=0x%02h, no byte expected", byte_o);
            end else begin
               exp = exp_q.pop_front();
               if (byte_o !== exp) begin
                  failures++;
                  $display("FAIL sb_byte: byte_o=0x%02h expected 0x%02h", byte_o, exp);
               end
            end
         end
         @(posedge clk_i);
         #2;
      end
      checks++;
      if (pops != 4 || last_pop != 3) begin
         failures++;
         $display("FAIL drain: %0d pops ending at cycle %0d expected 4 ending at 3", pops, last_pop);
      end
      checks++;
      if (byte_valid_o !== 1'b0 || overflow_o !== 1'b1) begin
         failures++;
         $display("FAIL drained_state: valid=%b overflow=%b expected 0/1", byte_valid_o, overflow_o);
      end
   endtask

   task automatic test_reset_midframe();
      int vcnt;
      logic [7:0] exp;
      vcnt = 0;
      @(posedge clk_i);
      #1;
      fork
         begin
            send_frame(8'hF0, 1'b1);
            repeat (10) @(posedge clk_i);
            #1;
            exp_q.push_back(8'h81);
            send_frame(8'h81, 1'b1);
         end
         begin
            repeat (88) @(posedge clk_i);
            #2;
            checks++;
            if (busy_o !== 1'b1) begin
               failures++;
               $display("FAIL busy_midframe: busy_o=%b expected 1", busy_o);
            end
            #1 rst_i = 1'b1;
            #1;
            checks++;
            if (byte_o !== 8'h00) begin
               failures++;
               $display("FAIL async_reset_byte: byte_o=0x%02h expected 0x00", byte_o);
            end
            checks++;
            if ({byte_valid_o, frame_err_o, parity_err_o, overflow_o, busy_o} !== 5'b0) begin
               failures++;
               $display("FAIL async_reset_flags: valid/ferr/perr/ovf/busy=%b expected 00000",
                        {byte_valid_o, frame_err_o, parity_err_o, overflow_o, busy_o});
            end
            repeat (2) @(posedge clk_i);
            #3 rst_i = 1'b0;
         end
         begin
            for (int c = 1; c <= 2 * FRAME_CYC + 30; c++) begin
               @(posedge clk_i);
               #2;
               if (byte_valid_o && byte_ready_i) begin
                  vcnt++;
                  checks++;
                  if (exp_q.size() == 0) begin
                     failures++;
                     $display("FAIL sb_unexpected: byte_o=0x%02h, no byte expected", byte_o);
                  end else begin
                     exp = exp_q.pop_front();
                     if (byte_o !== exp) begin
                        failures++;
                        $display("FAIL sb_byte: byte_o=0x%02h expected 0x%02h", byte_o, exp);
                     end
                  end
               end
            end
         end
      join
      checks++;
      if (vcnt != 1 || exp_q.size() != 0) begin
         failures++;
         $display("FAIL post_reset_bytes: %0d received, %0d missing expected 1/0", vcnt, exp_q.size());
      end
   endtask

`ifdef UART_MON_PARITY_EN
   task automatic test_parity();
      int perr, vcnt;
      logic [7:0] exp;
      for (int pass = 0; pass < 2; pass++) begin
         perr = 0; vcnt = 0;
         bad_par = (pass == 0);
         @(posedge clk_i);
         #1;
         if (pass == 1) exp_q.push_back(8'h07);
         fork
            send_frame(8'h07, 1'b1);
            begin
               for (int c = 1; c <= FRAME_CYC + 8; c++) begin
                  @(posedge clk_i);
                  #2;
                  if (parity_err_o) perr++;
                  if (byte_valid_o && byte_ready_i) begin
                     vcnt++;
                     checks++;
                     if (exp_q.size() == 0) begin
                        failures++;
                        $display("FAIL sb_unexpected: byte_o=0x%02h, no byte expected", byte_o);
                     end else begin
                        exp = exp_q.pop_front();
                        if (byte_o !== exp) begin
                           failures++;
                           $display("FAIL sb_byte: byte_o=0x%02h expected 0x%02h", byte_o, exp);
                        end
                     end
                  end
               end
            end
         join
         checks++;
         if (perr != ((pass == 0) ? 1 : 0)) begin
            failures++;
            $display("FAIL parity_err pass %0d: %0d pulses expected %0d", pass, perr, (pass == 0) ? 1 : 0);
         end
         checks++;
         if (vcnt != pass) begin
            failures++;
            $display("FAIL parity_bytes pass %0d: %0d received expected %0d", pass, vcnt, pass);
         end
      end
      bad_par = 1'b0;
   endtask
`endif

   initial begin
      #2_000_000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog expired");
   end

   initial begin
      test_reset();
      test_single_byte();
      test_glitch();
      test_frame_error();
      test_back_to_back();
      test_reset_midframe();
`ifdef UART_MON_PARITY_EN
      test_parity();
`endif
      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule
